// File: rtl/sha256_msg_ctrl_if.sv
// rtl/sha256_msg_ctrl_if.sv - host and sha256_update signal bundle for sha256_msg_ctrl
//
// Purpose: groups the host command/stream signals and the sha256_update
// control/data signals of sha256_msg_ctrl into a single interface.
// Ports (slave = controller side):
//   host   : start, msg_size[63:0], s_data[31:0], s_valid -> ctrl
//            s_ready, busy, digest_valid, error           <- ctrl
//   update : upd_block_offset[3:0], upd_done             -> ctrl
//            upd_reset, upd_en, upd_update, upd_msg_size[63:0], upd_w[31:0] <- ctrl
interface sha256_msg_ctrl_if;
   logic        start;
   logic [63:0] msg_size;
   logic [31:0] s_data;
   logic        s_valid;
   logic        s_ready;
   logic        busy;
   logic        digest_valid;
   logic        error;
   logic        upd_reset;
   logic        upd_en;
   logic        upd_update;
   logic [63:0] upd_msg_size;
   logic [31:0] upd_w;
   logic [3:0]  upd_block_offset;
   logic        upd_done;

   modport slave (
      input  start, msg_size, s_data, s_valid, upd_block_offset, upd_done,
      output s_ready, busy, digest_valid, error,
             upd_reset, upd_en, upd_update, upd_msg_size, upd_w
   );

   modport master (
      output start, msg_size, s_data, s_valid, upd_block_offset, upd_done,
      input  s_ready, busy, digest_valid, error,
             upd_reset, upd_en, upd_update, upd_msg_size, upd_w
   );
endinterface

// File: rtl/sha256_msg_ctrl.sv
// rtl/sha256_msg_ctrl.sv - host-side message sequencer for sha256_update
//
// Purpose: counts message words, stages each 512-bit block in a 16-word
// buffer served through a registered read port, issues one update per data
// block, waits for done with a watchdog, and flags digest_valid at the end.
// Ports:
//   clk   : single clock, rising edge
//   reset : asynchronous, active-high; clears all state
//   bus   : sha256_msg_ctrl_if.slave (host stream + sha256_update control)
module sha256_msg_ctrl #(
   parameter int TIMEOUT_CYCLES = 512,
   parameter int TO_W           = 10
) (
   input  logic              clk,
   input  logic              reset,
   sha256_msg_ctrl_if.slave  bus
);

   typedef enum logic [6:0] {
      S_IDLE   = 7'b0000001,
      S_CLEAR  = 7'b0000010,
      S_FILL   = 7'b0000100,
      S_UPDATE = 7'b0001000,
      S_WAIT   = 7'b0010000,
      S_DONE   = 7'b0100000,
      S_ERR    = 7'b1000000
   } state_t;

   state_t          r_state;
   state_t          w_next;

   logic [31:0]     r_buf [16];
   logic [4:0]      r_fill_idx;
   logic [58:0]     r_words_left;
   logic [TO_W-1:0] r_watchdog;
   logic [63:0]     r_msg_size;
   logic [31:0]     r_upd_w;

   logic            w_s_ready;
   logic            w_busy;
   logic            w_digest_valid;
   logic            w_error;
   logic            w_clear;
   logic            w_upd_en;
   logic            w_upd_update;
   logic            w_start_ok;
   logic            w_accept;
   logic            w_words_zero;
   logic            w_fill_full;
   logic            w_wd_expired;
   logic [58:0]     w_words_init;

   // ceil(msg_size/32) without a 65-bit adder: whole words plus one if a
   // partial word remains.
   assign w_words_init = bus.msg_size[63:5] + 59'(|bus.msg_size[4:0]);

   assign w_words_zero = (r_words_left == 59'd0);
   assign w_fill_full  = (r_fill_idx == 5'd16);
   assign w_wd_expired = (r_watchdog == TO_W'(TIMEOUT_CYCLES - 1));
   assign w_start_ok   = bus.start &
                         ((r_state == S_IDLE) | (r_state == S_DONE) | (r_state == S_ERR));
   assign w_accept     = bus.s_valid & w_s_ready;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) r_state <= S_IDLE;
      else       r_state <= w_next;
   end

   always_comb begin
      w_next         = r_state;
      w_s_ready      = 1'b0;
      w_busy         = 1'b1;
      w_digest_valid = 1'b0;
      w_error        = 1'b0;
      w_clear        = 1'b0;
      w_upd_en       = 1'b0;
      w_upd_update   = 1'b0;
      unique case (r_state)
         S_IDLE: begin
            w_busy = 1'b0;
            if (w_start_ok) w_next = S_CLEAR;
         end
         S_CLEAR: begin
            w_clear = 1'b1;
            w_next  = S_FILL;
         end
         S_FILL: begin
            w_upd_en  = 1'b1;
            w_s_ready = ~w_fill_full & ~w_words_zero;
            if (w_fill_full | w_words_zero) w_next = S_UPDATE;
         end
         S_UPDATE: begin
            w_upd_en     = 1'b1;
            w_upd_update = 1'b1;
            w_next       = S_WAIT;
         end
         S_WAIT: begin
            w_upd_en = 1'b1;
            if (bus.upd_done) w_next = w_words_zero ? S_DONE : S_FILL;
            else if (w_wd_expired) w_next = S_ERR;
         end
         S_DONE: begin
            w_busy         = 1'b0;
            w_digest_valid = 1'b1;
            if (w_start_ok) w_next = S_CLEAR;
         end
         S_ERR: begin
            w_busy  = 1'b0;
            w_error = 1'b1;
            if (w_start_ok) w_next = S_CLEAR;
         end
         default: w_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_fill_idx   <= 5'd0;
         r_words_left <= 59'd0;
         r_watchdog   <= '0;
         r_msg_size   <= 64'd0;
         r_upd_w      <= 32'd0;
      end else begin
         r_upd_w <= r_buf[bus.upd_block_offset];
         if (w_start_ok) begin
            r_words_left <= w_words_init;
            r_msg_size   <= bus.msg_size;
         end
         if (r_state == S_CLEAR) r_fill_idx <= 5'd0;
         if (w_accept) begin
            r_fill_idx   <= r_fill_idx + 5'd1;
            r_words_left <= r_words_left - 59'd1;
         end
         // Next block of a multi-block message starts filling from entry 0.
         if ((r_state == S_WAIT) & bus.upd_done & ~w_words_zero) r_fill_idx <= 5'd0;
         if (r_state == S_UPDATE)    r_watchdog <= '0;
         else if (r_state == S_WAIT) r_watchdog <= r_watchdog + 1'b1;
      end
   end

   // Buffer has no reset; stale entries of a short block are masked by the padder.
   always_ff @(posedge clk) begin
      if (w_accept) r_buf[r_fill_idx[3:0]] <= bus.s_data;
   end

   assign bus.s_ready      = w_s_ready;
   assign bus.busy         = w_busy;
   assign bus.digest_valid = w_digest_valid;
   assign bus.error        = w_error;
   // Reset also drives upd_reset so sha256_update is held cleared alongside us.
   assign bus.upd_reset    = reset | w_clear;
   assign bus.upd_en       = w_upd_en;
   assign bus.upd_update   = w_upd_update;
   assign bus.upd_msg_size = r_msg_size;
   assign bus.upd_w        = r_upd_w;

endmodule
